// File: rtl/bus_demux4_capture.sv
// Bus receiver: samples the shared bus on an accepted load and writes the word
// into one of four destination registers one cycle later, with loaded/write status.
module bus_demux4_capture #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [1:0]       select,
  input  logic             load,
  input  logic             enable,
  input  logic [3:0]       flag_clr,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [3:0]       loaded,
  output logic             wr_valid,
  output logic [1:0]       wr_sel,
  output logic             overwrite
);

  localparam int unsigned NUM_DEST = 4;

  logic                               accept_c;
  logic                               hold_valid_q, hold_valid_d;
  logic [1:0]                         hold_sel_q,   hold_sel_d;
  logic [WIDTH-1:0]                   hold_data_q,  hold_data_d;
  logic [NUM_DEST-1:0][WIDTH-1:0]     dest_q,       dest_d;
  logic [NUM_DEST-1:0]                loaded_q,     loaded_d;
  logic                               wr_valid_q,   wr_valid_d;
  logic [1:0]                         wr_sel_q,     wr_sel_d;
  logic                               overwrite_q,  overwrite_d;

  assign accept_c = load & enable;

  // Capture stage and write stage next-state; a write to i beats flag_clr[i].
  always_comb begin
    hold_valid_d = accept_c;
    hold_sel_d   = hold_sel_q;
    hold_data_d  = hold_data_q;
    dest_d       = dest_q;
    loaded_d     = loaded_q & ~flag_clr;
    wr_valid_d   = hold_valid_q;
    wr_sel_d     = wr_sel_q;
    overwrite_d  = 1'b0;
    if (accept_c) begin
      hold_sel_d  = select;
      hold_data_d = bus_in;
    end
    if (hold_valid_q) begin
      dest_d[hold_sel_q]   = hold_data_q;
      loaded_d[hold_sel_q] = 1'b1;
      wr_sel_d             = hold_sel_q;
      overwrite_d          = loaded_q[hold_sel_q] & ~flag_clr[hold_sel_q];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      hold_valid_q <= 1'b0;
      hold_sel_q   <= 2'b00;
      hold_data_q  <= '0;
      dest_q       <= {NUM_DEST{RESET_VAL}};
      loaded_q     <= '0;
      wr_valid_q   <= 1'b0;
      wr_sel_q     <= 2'b00;
      overwrite_q  <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_sel_q   <= hold_sel_d;
      hold_data_q  <= hold_data_d;
      dest_q       <= dest_d;
      loaded_q     <= loaded_d;
      wr_valid_q   <= wr_valid_d;
      wr_sel_q     <= wr_sel_d;
      overwrite_q  <= overwrite_d;
    end
  end

  assign q0        = dest_q[0];
  assign q1        = dest_q[1];
  assign q2        = dest_q[2];
  assign q3        = dest_q[3];
  assign loaded    = loaded_q;
  assign wr_valid  = wr_valid_q;
  assign wr_sel    = wr_sel_q;
  assign overwrite = overwrite_q;

endmodule

// File: tb/tb_bus_demux4_capture.sv
// Bench for bus_demux4_capture: directed vector table plus random traffic,
// both compared against a transfer-queue model of the receiver.
module tb_bus_demux4_capture;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             clr;
  logic [WIDTH-1:0] bus_in;
  logic [1:0]       select;
  logic             load;
  logic             enable;
  logic [3:0]       flag_clr;
  logic [WIDTH-1:0] q0, q1, q2, q3;
  logic [3:0]       loaded;
  logic             wr_valid;
  logic [1:0]       wr_sel;
  logic             overwrite;

  bus_demux4_capture #(.WIDTH(WIDTH), .RESET_VAL('0)) dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .select(select), .load(load),
    .enable(enable), .flag_clr(flag_clr), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .loaded(loaded), .wr_valid(wr_valid), .wr_sel(wr_sel), .overwrite(overwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       clr, load, en;
    logic [1:0] sel;
    logic [31:0] data;
    logic [3:0] fclr;
    logic       e_wv;
    logic [1:0] e_ws;
    logic       e_ov;
    logic [3:0] e_ld;
    logic [1:0] qi;
    logic [31:0] e_qv;
  } vec_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] data;
  } xfer_t;

  // Model: accepted transfers wait in a queue and land one edge later.
  logic [31:0] m_q [4];
  logic [3:0]  m_loaded;
  logic        m_wv, m_ov;
  logic [1:0]  m_ws;
  xfer_t       pend[$];

  task automatic model_step();
    logic [3:0] nl;
    xfer_t t;
    if (clr) begin
      for (int i = 0; i < 4; i++) m_q[i] = '0;
      m_loaded = '0; m_wv = 0; m_ov = 0; m_ws = 0;
      pend.delete();
    end else begin
      nl = m_loaded & ~flag_clr;
      m_wv = 0;
      m_ov = 0;
      if (pend.size() > 0) begin
        t = pend.pop_front();
        m_ov = m_loaded[t.sel] & ~flag_clr[t.sel];
        m_q[t.sel] = t.data;
        nl[t.sel] = 1'b1;
        m_wv = 1;
        m_ws = t.sel;
      end
      m_loaded = nl;
      if (load && enable) begin
        t.sel = select;
        t.data = bus_in;
        pend.push_back(t);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_q(input logic [1:0] i);
    case (i)
      2'd0: return q0;
      2'd1: return q1;
      2'd2: return q2;
      default: return q3;
    endcase
  endfunction

  task automatic check_model();
    for (int i = 0; i < 4; i++) chk($sformatf("model_q%0d", i), dut_q(2'(i)), m_q[i]);
    chk("model_loaded", 32'(loaded), 32'(m_loaded));
    chk("model_wr_valid", 32'(wr_valid), 32'(m_wv));
    chk("model_wr_sel", 32'(wr_sel), 32'(m_ws));
    chk("model_overwrite", 32'(overwrite), 32'(m_ov));
  endtask

  task automatic step(input logic c, input logic ld, input logic en, input logic [1:0] s,
                      input logic [31:0] d, input logic [3:0] fc);
    clr = c; load = ld; enable = en; select = s; bus_in = d; flag_clr = fc;
    @(posedge clk);
    #1;
    model_step();
    check_model();
  endtask

  function automatic vec_t mk(input logic c, input logic ld, input logic en, input logic [1:0] s,
                              input logic [31:0] d, input logic [3:0] fc, input logic wv,
                              input logic [1:0] ws, input logic ov, input logic [3:0] ldd,
                              input logic [1:0] qi, input logic [31:0] qv);
    vec_t v;
    v.clr = c; v.load = ld; v.en = en; v.sel = s; v.data = d; v.fclr = fc;
    v.e_wv = wv; v.e_ws = ws; v.e_ov = ov; v.e_ld = ldd; v.qi = qi; v.e_qv = qv;
    return v;
  endfunction

  vec_t vecs[19];

  initial begin
    clr = 1; load = 0; enable = 0; select = 0; bus_in = 0; flag_clr = 0;
    for (int i = 0; i < 4; i++) m_q[i] = '0;
    m_loaded = '0; m_wv = 0; m_ov = 0; m_ws = 0;

    //            clr ld en sel data          fclr   wv ws ov loaded qi  q value
    vecs[0]  = mk(1, 0, 0, 0, 32'h0,        4'h0,  0, 0, 0, 4'b0000, 2, 32'h0);
    vecs[1]  = mk(0, 0, 0, 0, 32'h0,        4'h0,  0, 0, 0, 4'b0000, 0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 0, 32'h0,        4'h0,  0, 0, 0, 4'b0000, 1, 32'h0);
    vecs[3]  = mk(0, 0, 0, 0, 32'h0,        4'h0,  0, 0, 0, 4'b0000, 3, 32'h0);
    vecs[4]  = mk(0, 1, 1, 2, 32'hDEADBEEF, 4'h0,  0, 0, 0, 4'b0000, 2, 32'h0);
    vecs[5]  = mk(0, 0, 0, 0, 32'h0,        4'h0,  1, 2, 0, 4'b0100, 2, 32'hDEADBEEF);
    vecs[6]  = mk(0, 0, 0, 0, 32'h0,        4'h0,  0, 2, 0, 4'b0100, 2, 32'hDEADBEEF);
    vecs[7]  = mk(1, 0, 0, 0, 32'h0,        4'h0,  0, 0, 0, 4'b0000, 2, 32'h0);
    vecs[8]  = mk(0, 1, 1, 0, 32'h11,       4'h0,  0, 0, 0, 4'b0000, 0, 32'h0);
    vecs[9]  = mk(0, 1, 1, 1, 32'h22,       4'h0,  1, 0, 0, 4'b0001, 0, 32'h11);
    vecs[10] = mk(0, 1, 1, 0, 32'h33,       4'h0,  1, 1, 0, 4'b0011, 1, 32'h22);
    vecs[11] = mk(0, 1, 1, 1, 32'h44,       4'h0,  1, 0, 1, 4'b0011, 0, 32'h33);
    vecs[12] = mk(0, 0, 0, 0, 32'h0,        4'h3,  1, 1, 0, 4'b0010, 1, 32'h44);
    vecs[13] = mk(0, 1, 0, 3, 32'h55,       4'h0,  0, 1, 0, 4'b0010, 3, 32'h0);
    vecs[14] = mk(0, 0, 0, 0, 32'h0,        4'h0,  0, 1, 0, 4'b0010, 3, 32'h0);
    vecs[15] = mk(0, 1, 1, 3, 32'hCAFE,     4'h0,  0, 1, 0, 4'b0010, 3, 32'h0);
    vecs[16] = mk(1, 1, 1, 3, 32'h77,       4'h0,  0, 0, 0, 4'b0000, 3, 32'h0);
    vecs[17] = mk(0, 0, 0, 0, 32'h0,        4'h0,  0, 0, 0, 4'b0000, 3, 32'h0);
    vecs[18] = mk(0, 0, 0, 0, 32'h0,        4'h0,  0, 0, 0, 4'b0000, 3, 32'h0);

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].sel, vecs[i].data, vecs[i].fclr);
      chk($sformatf("vec%0d_wr_valid", i), 32'(wr_valid), 32'(vecs[i].e_wv));
      chk($sformatf("vec%0d_wr_sel", i), 32'(wr_sel), 32'(vecs[i].e_ws));
      chk($sformatf("vec%0d_overwrite", i), 32'(overwrite), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_loaded", i), 32'(loaded), 32'(vecs[i].e_ld));
      chk($sformatf("vec%0d_q%0d", i, vecs[i].qi), dut_q(vecs[i].qi), vecs[i].e_qv);
    end

    // Sustained back-to-back writes to one destination: last write wins.
    step(0, 1, 1, 2, 32'hA1, 4'h0);
    step(0, 1, 1, 2, 32'hA2, 4'h0);
    step(0, 1, 1, 2, 32'hA3, 4'h0);
    step(0, 0, 0, 0, 32'h0, 4'h0);
    chk("b2b_q2", q2, 32'hA3);
    chk("b2b_overwrite", 32'(overwrite), 32'h1);
    step(0, 0, 0, 0, 32'h0, 4'h4);
    chk("flagclr_loaded", 32'(loaded), 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
           2'($urandom_range(0, 3)), $urandom(),
           ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_demux4_capture.md
# bus_demux4_capture

Bus receiver for the datapath: the counterpart of the 4-to-1 tri-state bus driver. It samples the 32-bit shared bus on a load strobe and steers the sampled word into one of four destination registers through a two-stage pipeline. It keeps per-destination "loaded" status for the control unit and reports every write it performs. It sits on the bus at the receiving end, opposite the source-select drivers.

## Interface
- WIDTH, 32, data width of bus and destination registers
- RESET_VAL, 0, value loaded into q0..q3 on reset

- clk  input  1  system clock, all state updates on rising edge
- clr  input  1  synchronous, active-high reset
- bus_in  input  WIDTH  shared bus value, sampled only on accepted load
- select  input  2  destination index, sampled with bus_in
- load  input  1  capture strobe; one transfer per cycle it is high
- enable  input  1  qualifies load; load with enable low is ignored
- flag_clr  input  4  per-destination clear of loaded flags
- q0, q1, q2, q3  output  WIDTH  destination registers
- loaded  output  4  sticky flag, bit i set when qi has been written since reset/flag_clr
- wr_valid  output  1  high for one cycle after a destination write
- wr_sel  output  2  index written, valid when wr_valid high
- overwrite  output  1  with wr_valid: destination was already loaded

## Operation
- Accept condition: load & enable at a rising edge (and clr low).
- Stage 1 (capture): on accept, hold_data <= bus_in, hold_sel <= select, hold_valid <= 1; otherwise hold_valid <= 0. A new accept every cycle is legal; no back-pressure, no ready signal.
- Stage 2 (write): when hold_valid is 1 at an edge, q[hold_sel] <= hold_data, loaded[hold_sel] <= 1, wr_valid <= 1, wr_sel <= hold_sel, overwrite <= loaded[hold_sel] & ~flag_clr[hold_sel]. When hold_valid is 0, wr_valid <= 0 and overwrite <= 0; wr_sel holds its value.
- flag_clr[i] at an edge clears loaded[i], unless stage 2 writes destination i at that same edge; in that case the write wins and loaded[i] ends at 1.
- Registers not addressed by a write hold their value. Consecutive writes to the same index resolve in order: the last write wins.
- select is fully decoded; there are no illegal values.
- clr: on an edge with clr high: q0..q3 <= RESET_VAL; loaded, wr_valid, overwrite, wr_sel, hold_valid <= 0; hold_data <= 0. Any load in that cycle is dropped, and any in-flight hold is discarded without being written. clr overrides load, flag_clr and the stage-2 write.

## Timing
- Reset values: q0..q3 = RESET_VAL, loaded = 4'b0000, wr_valid = 0, wr_sel = 2'b00, overwrite = 0.
- Latency: accept at edge N → destination updated at edge N+1. The qi value, the loaded bit, wr_valid, wr_sel and overwrite are all visible in cycle N+1 (after edge N+1).
- Throughput: one word per cycle. wr_valid high for k consecutive cycles follows k consecutive accepts.
- bus_in and select only need to be stable around the accepting edge. Bus changes at other times have no effect.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- clr asserted at edge N+1 after an accept at edge N: the write is lost and wr_valid stays 0.

## Test plan
- Reset, then idle for 3 cycles → q0..q3 = 0, loaded = 0000, wr_valid = 0.
- Accept bus_in = 0xDEADBEEF, select = 2 at edge N → q2 = 0xDEADBEEF and wr_valid = 1, wr_sel = 2, overwrite = 0, loaded = 0100 in cycle N+1. wr_valid = 0 in cycle N+2.
- Back-to-back accepts of 0x11 (sel 0), 0x22 (sel 1), 0x33 (sel 0) → wr_valid high 3 cycles, wr_sel = 0,1,0, overwrite = 0,0,1; final q0 = 0x33, q1 = 0x22, loaded = 0011.
- With loaded = 0011, a write to sel 1 pipelined so it lands at the same edge as flag_clr = 0011 → loaded = 0010 and overwrite = 0 for that write. Also: load high with enable low → no write, wr_valid stays 0.
- Accept 0xCAFE (sel 3) at edge N, clr high at edge N+1 → q3 = 0, wr_valid = 0, loaded = 0000. Also: load held high throughout a clr cycle is ignored.
